// File: rtl/xif_mem_responder_if.sv
// Coprocessor memory request/result bundle between a core (master)
// and the xif_mem_responder (slave).
interface xif_mem_responder_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic [X_ID_WIDTH-1:0] mem_req_id;
  logic [31:0]           mem_req_addr;
  logic                  mem_req_we;
  logic [3:0]            mem_req_be;
  logic [2:0]            mem_req_size;
  logic [31:0]           mem_req_wdata;
  logic                  mem_resp_exc;
  logic [5:0]            mem_resp_exccode;
  logic                  mem_result_valid;
  logic [X_ID_WIDTH-1:0] mem_result_id;
  logic [31:0]           mem_result_rdata;
  logic                  mem_result_err;

  modport master (
    output mem_valid, mem_req_id, mem_req_addr,
    output mem_req_we, mem_req_be, mem_req_size,
    output mem_req_wdata,
    input  mem_ready, mem_resp_exc, mem_resp_exccode,
    input  mem_result_valid, mem_result_id,
    input  mem_result_rdata, mem_result_err
  );

  modport slave (
    input  mem_valid, mem_req_id, mem_req_addr,
    input  mem_req_we, mem_req_be, mem_req_size,
    input  mem_req_wdata,
    output mem_ready, mem_resp_exc, mem_resp_exccode,
    output mem_result_valid, mem_result_id,
    output mem_result_rdata, mem_result_err
  );
endinterface

// File: rtl/xif_mem_responder.sv
// In-order memory responder with a request FIFO and fixed latency.
// Define XIF_MEM_RANDOM_STALL_EN to throttle mem_ready with an LFSR.
module xif_mem_responder #(
  parameter int X_ID_WIDTH  = 4,
  parameter int MEM_WORDS   = 256,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 2
) (
  input logic ck,
  input logic rst,
  xif_mem_responder_if.slave bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [PW:0] FULLC = (PW+1)'(QUEUE_DEPTH);
  localparam logic [PW:0] ONE   = (PW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [X_ID_WIDTH-1:0] id_q    [QUEUE_DEPTH];
  logic                  we_q    [QUEUE_DEPTH];
  logic [3:0]            be_q    [QUEUE_DEPTH];
  logic [29:0]           waddr_q [QUEUE_DEPTH];
  logic [31:0]           wdata_q [QUEUE_DEPTH];
  logic [31:0]           mem_q   [MEM_WORDS];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] lat_q, lat_d;

  logic full, empty, ready, accept, push, pop, mis;
  logic resp, h_err;
  logic [29:0]   h_waddr;
  logic [AW-1:0] h_idx;

  assign full  = (cnt_q == FULLC);
  assign empty = (cnt_q == '0);

`ifdef XIF_MEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0],
                        lfsr_q[7] ^ lfsr_q[5] ^
                        lfsr_q[4] ^ lfsr_q[3]};
  end
  assign ready = !rst && !full && (lfsr_q[1:0] != 2'b00);
`else
  assign ready = !rst && !full;
`endif

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      bus.mem_req_size > 3'd2:  mis = 1'b1;
      bus.mem_req_size == 3'd2: mis = |bus.mem_req_addr[1:0];
      bus.mem_req_size == 3'd1: mis = bus.mem_req_addr[0];
      default:                  mis = 1'b0;
    endcase
  end

  assign accept = bus.mem_valid && ready;
  assign push   = accept && !mis;
  assign resp   = (state_q == S_RESP);
  assign pop    = resp;

  assign bus.mem_ready        = ready;
  assign bus.mem_resp_exc     = accept && mis;
  assign bus.mem_resp_exccode =
    !(accept && mis) ? 6'd0 :
    bus.mem_req_we   ? 6'd6 : 6'd4;

  assign h_waddr = waddr_q[rd_ptr_q];
  assign h_idx   = h_waddr[AW-1:0];
  assign h_err   = (h_waddr >= 30'(MEM_WORDS));

  assign bus.mem_result_valid = resp;
  assign bus.mem_result_id    = resp ? id_q[rd_ptr_q] : '0;
  assign bus.mem_result_err   = resp && h_err;
  assign bus.mem_result_rdata =
    (resp && !we_q[rd_ptr_q] && !h_err) ? mem_q[h_idx] : 32'h0;

  // Payload and memory carry no reset; count/pointers define validity
  always_ff @(posedge ck) begin
    if (push) begin
      id_q[wr_ptr_q]    <= bus.mem_req_id;
      we_q[wr_ptr_q]    <= bus.mem_req_we;
      be_q[wr_ptr_q]    <= bus.mem_req_be;
      waddr_q[wr_ptr_q] <= bus.mem_req_addr[31:2];
      wdata_q[wr_ptr_q] <= bus.mem_req_wdata;
    end
    if (resp && we_q[rd_ptr_q] && !h_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[rd_ptr_q][b])
          mem_q[h_idx][8*b +: 8] <= wdata_q[rd_ptr_q][8*b +: 8];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // A head that was already queued behind the popped entry is re-aged
  // through WAIT; a freshly pushed head goes through IDLE first.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          lat_d   = '0;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAST) state_d = S_RESP;
        else               lat_d   = lat_q + 1'b1;
      end
      S_RESP: begin
        lat_d = '0;
        if (cnt_q > ONE)
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        else
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      lat_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end
endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder (default parameters).
// Results are captured by a negedge monitor and checked in order.
module tb_xif_mem_responder;
  localparam int IDW = 4;
  localparam int MW  = 256;
  localparam int QD  = 4;
  localparam int LAT = 2;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  xif_mem_responder_if #(.X_ID_WIDTH(IDW)) bus();

  xif_mem_responder #(
    .X_ID_WIDTH(IDW), .MEM_WORDS(MW),
    .QUEUE_DEPTH(QD), .LATENCY(LAT)
  ) dut (
    .ck(ck), .rst(rst), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  int          r_id  [$];
  logic [31:0] r_dat [$];
  logic        r_err [$];
  int          r_cyc [$];

  always @(negedge ck) begin
    ncyc = ncyc + 1;
    if (bus.mem_result_valid) begin
      r_id.push_back(int'(bus.mem_result_id));
      r_dat.push_back(bus.mem_result_rdata);
      r_err.push_back(bus.mem_result_err);
      r_cyc.push_back(ncyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [31:0] a,
                       input logic we, input logic [3:0] be,
                       input logic [2:0] sz, input logic [31:0] wd);
    bus.mem_valid     = 1'b1;
    bus.mem_req_id    = id;
    bus.mem_req_addr  = a;
    bus.mem_req_we    = we;
    bus.mem_req_be    = be;
    bus.mem_req_size  = sz;
    bus.mem_req_wdata = wd;
  endtask

  task automatic send(input logic [3:0] id, input logic [31:0] a,
                      input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output int acc);
    int t;
    t = 0;
    drive(id, a, we, be, 3'd2, wd);
    #1;
    while (!bus.mem_ready && t < 50) begin
      @(negedge ck); #1; t++;
    end
    chk("accept_bound", 64'(t < 50), 64'd1);
    chk("exc_legal", 64'(bus.mem_resp_exc), 64'd0);
    acc = ncyc;
    @(negedge ck); #1;
    bus.mem_valid = 1'b0;
  endtask

  task automatic wait_res(input int k);
    int t;
    t = 0;
    while (r_id.size() < k && t < 100) begin
      @(negedge ck); #1; t++;
    end
    chk("result_count", 64'(r_id.size()), 64'(k));
  endtask

  task automatic pop_res(output int id, output logic [31:0] d,
                         output logic e, output int c);
    id = -1; d = 'x; e = 'x; c = -1;
    if (r_id.size() > 0) begin
      id = r_id.pop_front();
      d  = r_dat.pop_front();
      e  = r_err.pop_front();
      c  = r_cyc.pop_front();
    end
  endtask

  task automatic mis_req(input string tag, input logic we,
                         input logic [31:0] a, input logic [2:0] sz,
                         input logic [5:0] code);
    drive(4'hF, a, we, 4'hF, sz, 32'h0);
    #1;
    chk({tag, "_exc"}, 64'(bus.mem_resp_exc), 64'd1);
    chk({tag, "_code"}, 64'(bus.mem_resp_exccode), 64'(code));
    @(negedge ck); #1;
    bus.mem_valid = 1'b0;
    #1;
    chk({tag, "_exc_off"}, 64'(bus.mem_resp_exc), 64'd0);
  endtask

  initial begin
    int a0, a1, acc[6], id, c;
    logic [31:0] d;
    logic e;

    drive(4'h0, 32'h6, 1'b0, 4'h0, 3'd2, 32'h0);
    #1 rst = 1'b1;
    repeat (2) @(negedge ck);
    #1;
    chk("rst_ready", 64'(bus.mem_ready), 64'd0);
    chk("rst_exc", 64'(bus.mem_resp_exc), 64'd0);
    chk("rst_code", 64'(bus.mem_resp_exccode), 64'd0);
    chk("rst_rvalid", 64'(bus.mem_result_valid), 64'd0);
    chk("rst_rid", 64'(bus.mem_result_id), 64'd0);
    chk("rst_rdata", 64'(bus.mem_result_rdata), 64'd0);
    chk("rst_rerr", 64'(bus.mem_result_err), 64'd0);
    bus.mem_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.mem_ready), 64'd1);

    send(4'd1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, a0);
    send(4'd2, 32'h10, 1'b0, 4'h0, 32'h0, a1);
    wait_res(2);
    pop_res(id, d, e, c);
    chk("st_id", 64'(id), 64'd1);
    chk("st_rdata", 64'(d), 64'd0);
    chk("st_err", 64'(e), 64'd0);
    chk("st_latency", 64'(c - a0), 64'(LAT + 1));
    pop_res(id, d, e, c);
    chk("ld_id", 64'(id), 64'd2);
    chk("ld_rdata", 64'(d), 64'hDEADBEEF);
    chk("ld_err", 64'(e), 64'd0);

    send(4'd3, 32'h20, 1'b1, 4'hF, 32'h11223344, a0);
    send(4'd4, 32'h20, 1'b1, 4'h3, 32'h0000CAFE, a0);
    send(4'd5, 32'h20, 1'b0, 4'h0, 32'h0, a0);
    send(4'd6, 32'h20, 1'b1, 4'h4, 32'h00AB0000, a0);
    send(4'd7, 32'h20, 1'b0, 4'h0, 32'h0, a0);
    wait_res(5);
    repeat (2) pop_res(id, d, e, c);
    pop_res(id, d, e, c);
    chk("be3_id", 64'(id), 64'd5);
    chk("be3_rdata", 64'(d), 64'h1122CAFE);
    pop_res(id, d, e, c);
    pop_res(id, d, e, c);
    chk("be4_id", 64'(id), 64'd7);
    chk("be4_rdata", 64'(d), 64'h11ABCAFE);

    drive(4'd8, 32'h22, 1'b0, 4'h0, 3'd1, 32'h0);
    @(negedge ck); #1;
    bus.mem_valid = 1'b0;
    wait_res(1);
    pop_res(id, d, e, c);
    chk("half_id", 64'(id), 64'd8);
    chk("half_rdata", 64'(d), 64'h11ABCAFE);

    mis_req("mis_ld_w", 1'b0, 32'h6, 3'd2, 6'd4);
    mis_req("mis_st_h", 1'b1, 32'h21, 3'd1, 6'd6);
    mis_req("mis_size3", 1'b0, 32'h0, 3'd3, 6'd4);
    repeat (6) @(negedge ck);
    #1;
    chk("mis_no_result", 64'(r_id.size()), 64'd0);

    for (int i = 0; i < 6; i++)
      send(4'(3 + i), 32'h20, 1'b0, 4'h0, 32'h0, acc[i]);
    chk("b2b_5th_acc", 64'(acc[4] - acc[0]), 64'd4);
    chk("b2b_6th_stall", 64'(acc[5] - acc[0]), 64'd6);
    wait_res(6);
    for (int i = 0; i < 6; i++) begin
      pop_res(id, d, e, c);
      chk("b2b_id", 64'(id), 64'(3 + i));
      chk("b2b_rdata", 64'(d), 64'h11ABCAFE);
    end

    send(4'd9, 32'h400, 1'b0, 4'h0, 32'h0, a0);
    wait_res(1);
    pop_res(id, d, e, c);
    chk("oob_err", 64'(e), 64'd1);
    chk("oob_rdata", 64'(d), 64'd0);
    chk("oob_latency", 64'(c - a0), 64'(LAT + 1));
    send(4'd10, 32'h400, 1'b1, 4'hF, 32'h12345678, a0);
    send(4'd11, 32'h3FC, 1'b1, 4'hF, 32'hA5A55A5A, a0);
    send(4'd12, 32'h3FC, 1'b0, 4'h0, 32'h0, a0);
    wait_res(3);
    pop_res(id, d, e, c);
    chk("oob_st_err", 64'(e), 64'd1);
    pop_res(id, d, e, c);
    chk("last_st_err", 64'(e), 64'd0);
    pop_res(id, d, e, c);
    chk("last_ld_err", 64'(e), 64'd0);
    chk("last_ld_rdata", 64'(d), 64'hA5A55A5A);

    for (int i = 0; i < 4; i++)
      send(4'(i), 32'h10, 1'b0, 4'h0, 32'h0, a0);
    chk("pre_rst_results", 64'(r_id.size()), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus.mem_ready), 64'd0);
    chk("mid_rst_rvalid", 64'(bus.mem_result_valid), 64'd0);
    r_id.delete(); r_dat.delete(); r_err.delete(); r_cyc.delete();
    repeat (2) @(negedge ck);
    #1 rst = 1'b0;
    repeat (8) @(negedge ck);
    #1;
    chk("post_rst_no_result", 64'(r_id.size()), 64'd0);
    send(4'd13, 32'h10, 1'b0, 4'h0, 32'h0, a0);
    wait_res(1);
    pop_res(id, d, e, c);
    chk("after_rst_id", 64'(id), 64'd13);
    chk("after_rst_rdata", 64'(d), 64'hDEADBEEF);
    chk("after_rst_latency", 64'(c - a0), 64'(LAT + 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
